// File: rtl/ir_encoder.sv
// ir_encoder: NEC infrared transmitter producing a carrier-modulated frame from a 32-bit command or a repeat request
module ir_encoder #(
  parameter int clk_hz       = 25000000,
  parameter int unit_cycles  = 14062,
  parameter int carrier_half = 329,
  parameter int gap_units    = 64,
  parameter bit modulate     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        repeat_frame,
  input  logic [31:0] command,
  output logic        ready,
  output logic        done,
  output logic        envelope,
  output logic        ir_out
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEAD_B = 3'd1;
  localparam logic [2:0] S_LEAD_S = 3'd2;
  localparam logic [2:0] S_BIT_B  = 3'd3;
  localparam logic [2:0] S_BIT_S  = 3'd4;
  localparam logic [2:0] S_STOP_B = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;
  localparam int max_units = gap_units > 16 ? gap_units : 16;
  localparam int lw = $clog2(max_units * unit_cycles + 1);
  localparam int pw = $clog2(carrier_half + 1);
  localparam logic [lw-1:0] c_lead  = lw'(16 * unit_cycles - 1);
  localparam logic [lw-1:0] c_sp8   = lw'(8 * unit_cycles - 1);
  localparam logic [lw-1:0] c_sp4   = lw'(4 * unit_cycles - 1);
  localparam logic [lw-1:0] c_one   = lw'(unit_cycles - 1);
  localparam logic [lw-1:0] c_three = lw'(3 * unit_cycles - 1);
  localparam logic [lw-1:0] c_gap   = lw'(gap_units * unit_cycles - 1);
  localparam logic [pw-1:0] c_ph    = pw'(carrier_half - 1);

  if (clk_hz < 1 || unit_cycles < 2 || carrier_half < 1 || gap_units < 0) begin : g_bad_params
    $error("ir_encoder: invalid parameters");
  end

  logic [2:0]    r_state, w_ns;
  logic [lw-1:0] r_left, w_nl;
  logic [4:0]    r_bit, w_nb;
  logic [31:0]   r_cmd;
  logic          r_rpt;
  logic [pw-1:0] r_ph, w_nph;
  logic          r_car, w_ncar;
  logic          r_ready, r_done, r_env, r_ir;
  logic          w_done, w_last, w_acc, w_nenv, w_step, w_wrap;

  assign w_last   = r_left == '0;
  assign w_acc    = r_ready && valid;
  assign ready    = r_ready;
  assign done     = r_done;
  assign envelope = r_env;
  assign ir_out   = r_ir;

  // Next state, remaining-cycle count and bit index; each state loads its full length on entry
  always_comb begin
    w_ns   = r_state;
    w_nl   = r_left - lw'(1);
    w_nb   = r_bit;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) begin
        w_ns = S_LEAD_B;
        w_nl = c_lead;
      end
      S_LEAD_B: if (w_last) begin
        w_ns = S_LEAD_S;
        w_nl = r_rpt ? c_sp4 : c_sp8;
      end
      S_LEAD_S: if (w_last) begin
        w_ns = r_rpt ? S_STOP_B : S_BIT_B;
        w_nl = c_one;
        w_nb = '0;
      end
      S_BIT_B: if (w_last) begin
        w_ns = S_BIT_S;
        w_nl = r_cmd[r_bit] ? c_three : c_one;
      end
      S_BIT_S: if (w_last) begin
        w_ns = &r_bit ? S_STOP_B : S_BIT_B;
        w_nl = c_one;
        w_nb = r_bit + 5'd1;
      end
      S_STOP_B: if (w_last) begin
        w_ns   = gap_units == 0 ? S_IDLE : S_GAP;
        w_nl   = c_gap;
        w_done = gap_units == 0;
      end
      S_GAP: if (w_last) begin
        w_ns   = S_IDLE;
        w_done = 1'b1;
      end
      default: w_ns = S_IDLE;
    endcase
  end

  // Carrier phase for the upcoming cycle; held cleared unless a burst continues so every burst starts high
  always_comb begin
    w_nenv = w_ns == S_LEAD_B || w_ns == S_BIT_B || w_ns == S_STOP_B;
    w_step = r_env && w_nenv;
    w_wrap = r_ph == c_ph;
    w_nph  = !w_step || w_wrap ? '0 : r_ph + pw'(1);
    w_ncar = !w_step ? 1'b1 : w_wrap ? ~r_car : r_car;
  end

  // Register FSM, latched request and all outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_left  <= '0;
      r_bit   <= '0;
      r_cmd   <= '0;
      r_rpt   <= 1'b0;
      r_ph    <= '0;
      r_car   <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_env   <= 1'b0;
      r_ir    <= 1'b0;
    end else begin
      r_state <= w_ns;
      r_left  <= w_nl;
      r_bit   <= w_nb;
      if (w_acc) begin
        r_cmd <= command;
        r_rpt <= repeat_frame;
      end
      r_ph    <= w_nph;
      r_car   <= w_ncar;
      r_ready <= w_ns == S_IDLE;
      r_done  <= w_done;
      r_env   <= w_nenv;
      r_ir    <= w_nenv && (modulate ? w_ncar : 1'b1);
    end
  end
endmodule

// File: tb/tb_ir_encoder.sv
// tb_ir_encoder: checks ir_encoder frames against a segment-list model of the NEC waveform
module tb_ir_encoder;
  localparam int U = 10, H = 2, G = 4;

  logic        clk = 1'b0, rst = 1'b0, valid = 1'b0, repeat_frame = 1'b0;
  logic [31:0] command = '0;
  logic        ready, done, envelope, ir_out;
  logic        ready_b, done_b, envelope_b, ir_out_b;
  int          checks = 0, errors = 0;
  bit          exp_env[$];
  bit          exp_ir[$];

  typedef struct {
    logic [31:0] cmd;
    logic        rpt;
    int          len;
    int          pulse;
  } vec_t;
  vec_t tbl[6];

  ir_encoder #(.clk_hz(25000000), .unit_cycles(U), .carrier_half(H), .gap_units(G), .modulate(1'b1)) dut (
    .clk(clk), .rst(rst), .valid(valid), .repeat_frame(repeat_frame), .command(command),
    .ready(ready), .done(done), .envelope(envelope), .ir_out(ir_out));

  ir_encoder #(.clk_hz(25000000), .unit_cycles(U), .carrier_half(H), .gap_units(G), .modulate(1'b0)) dut_b (
    .clk(clk), .rst(rst), .valid(valid), .repeat_frame(repeat_frame), .command(command),
    .ready(ready_b), .done(done_b), .envelope(envelope_b), .ir_out(ir_out_b));

  always #5 clk = ~clk;

  task automatic summary;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic void push(input bit lvl, input int units);
    for (int k = 0; k < units * U; k++) begin
      exp_env.push_back(lvl);
      exp_ir.push_back(lvl && ((k / H) % 2 == 0));
    end
  endfunction

  function automatic void build(input logic [31:0] c, input logic r);
    exp_env.delete();
    exp_ir.delete();
    push(1, 16);
    if (r) push(0, 4);
    else begin
      push(0, 8);
      for (int i = 0; i < 32; i++) begin
        push(1, 1);
        push(0, c[i] ? 3 : 1);
      end
    end
    push(1, 1);
    push(0, G);
  endfunction

  task automatic start_frame(input logic [31:0] c, input logic r);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", ready, 1);
      summary();
    end
    valid = 1'b1;
    command = c;
    repeat_frame = r;
    build(c, r);
    @(posedge clk);
  endtask

  task automatic check_frame(input string name, input int len, input int pulse_at, input bit hold, input logic [31:0] next_cmd);
    string sn[6] = '{"envelope", "ir_out", "ready", "done", "nomod_ir_out", "nomod_envelope"};
    int    bad[6];
    int    first[6];
    logic  gv[6], wv[6], g[6], w[6];
    bit    we, wi;
    for (int s = 0; s < 6; s++) begin
      bad[s] = 0;
      first[s] = 0;
      gv[s] = 1'b0;
      wv[s] = 1'b0;
    end
    for (int i = 0; i <= (hold ? len : len + 1); i++) begin
      @(negedge clk);
      we = i < len && i < exp_env.size() ? exp_env[i] : 1'b0;
      wi = i < len && i < exp_ir.size() ? exp_ir[i] : 1'b0;
      g = '{envelope, ir_out, ready, done, ir_out_b, envelope_b};
      w = '{we, wi, i >= len, i == len, we, we};
      for (int s = 0; s < 6; s++)
        if (g[s] !== w[s]) begin
          if (bad[s] == 0) begin
            first[s] = i;
            gv[s] = g[s];
            wv[s] = w[s];
          end
          bad[s]++;
        end
      if (i == 0) begin
        valid = 1'b0;
        command = $urandom;
        repeat_frame = 1'($urandom);
      end
      if (pulse_at > 0 && i == pulse_at) begin
        valid = 1'b1;
        command = $urandom;
      end
      if (pulse_at > 0 && i == pulse_at + 1) valid = 1'b0;
      if (hold && i == len - 5) begin
        valid = 1'b1;
        command = next_cmd;
        repeat_frame = 1'b0;
      end
    end
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (bad[s] != 0) begin
        errors++;
        $display("FAIL %s.%s: %0d cycles wrong, first at cycle %0d got %b want %b",
                 name, sn[s], bad[s], first[s], gv[s], wv[s]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    summary();
  end

  initial begin
    int quiet;
    logic [31:0] c;
    logic r;
    tbl[0] = '{32'h00FF00FF, 1'b0, 1250, -1};
    tbl[1] = '{32'hDEADBEEF, 1'b1, 250, -1};
    tbl[2] = '{32'h00000000, 1'b0, 930, 300};
    tbl[3] = '{32'hFFFFFFFF, 1'b0, 1570, -1};
    tbl[4] = '{32'h00000001, 1'b0, 950, 700};
    tbl[5] = '{32'h80000000, 1'b0, 950, -1};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("reset_ready", ready, 1);
    chk("reset_envelope", envelope, 0);
    chk("reset_ir_out", ir_out, 0);
    chk("reset_done", done, 0);
    chk("reset_nomod", {ready_b, done_b, envelope_b, ir_out_b}, 4'b1000);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (envelope || ir_out || done || !ready) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    for (int i = 0; i < 6; i++) begin
      start_frame(tbl[i].cmd, tbl[i].rpt);
      check_frame($sformatf("vec%0d", i), tbl[i].len, tbl[i].pulse, 1'b0, 32'h0);
    end

    start_frame(32'hA5A5A5A5, 1'b0);
    check_frame("b2b_first", 1250, -1, 1'b1, 32'h12345678);
    build(32'h12345678, 1'b0);
    check_frame("b2b_second", exp_env.size(), -1, 1'b0, 32'h0);

    for (int i = 0; i < 6; i++) begin
      c = $urandom;
      r = $urandom_range(0, 3) == 0;
      start_frame(c, r);
      check_frame($sformatf("rand%0d_%h_%0d", i, c, r), exp_env.size(),
                  $urandom_range(0, 1) == 1 ? int'($urandom_range(20, 200)) : -1, 1'b0, 32'h0);
    end

    start_frame(32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    repeat (645) @(negedge clk);
    chk("pre_reset_envelope", envelope, exp_env[645]);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_envelope", envelope, 0);
    chk("midreset_ir_out", ir_out, 0);
    chk("midreset_ready", ready, 1);
    chk("midreset_done", done, 0);
    quiet = 0;
    repeat (2) begin
      @(negedge clk);
      if (done || envelope) quiet++;
    end
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done || envelope || ir_out || !ready) quiet++;
    end
    chk("post_reset_quiet", quiet, 0);
    start_frame(32'h00FF00FF, 1'b0);
    check_frame("after_reset", 1250, -1, 1'b0, 32'h0);

    summary();
  end
endmodule
